// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, access sizes and FSM states for the memory stage
package mem_stage_pkg;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2,
        MEM_SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute, data-bus and write-back signals of the memory stage
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic               ex_valid;
    logic               ex_ready;
    logic [XLEN-1:0]    ex_rd_data;
    logic [XLEN-1:0]    ex_store_data;
    logic               ex_mem_rd;
    logic               ex_mem_wr;
    logic [1:0]         ex_mem_size;
    logic               ex_mem_unsigned;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_rd_wen;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_req_we;
    logic [XLEN-1:0]    mem_req_wdata;
    logic [7:0]         mem_req_wmask;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rsp_rdata;

    logic               wb_valid;
    logic [RADDR_W-1:0] wb_rd_addr;
    logic               wb_rd_wen;
    logic [XLEN-1:0]    wb_rd_data;
    logic               wb_misalign;

    modport master (
        input  ex_valid, ex_rd_data, ex_store_data, ex_mem_rd, ex_mem_wr,
               ex_mem_size, ex_mem_unsigned, ex_rd_addr, ex_rd_wen,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output ex_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
               mem_req_wmask, wb_valid, wb_rd_addr, wb_rd_wen, wb_rd_data, wb_misalign
    );

    modport slave (
        output ex_valid, ex_rd_data, ex_store_data, ex_mem_rd, ex_mem_wr,
               ex_mem_size, ex_mem_unsigned, ex_rd_addr, ex_rd_wen,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  ex_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
               mem_req_wmask, wb_valid, wb_rd_addr, wb_rd_wen, wb_rd_data, wb_misalign
    );

endinterface

// File: rtl/mem_stage_align.sv
// rtl/mem_stage_align.sv - byte-lane placement for stores, lane extract/extend for loads, alignment check
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      req_off_i,
    input  mem_size_e       req_size_i,
    input  logic [XLEN-1:0] req_store_data_i,
    output logic [XLEN-1:0] req_wdata_o,
    output logic [7:0]      req_wmask_o,
    output logic            req_misalign_o,
    input  logic [2:0]      ld_off_i,
    input  mem_size_e       ld_size_i,
    input  logic            ld_unsigned_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] lane;

    always_comb begin
        req_wdata_o    = req_store_data_i << {req_off_i, 3'b000};
        req_wmask_o    = 8'h00;
        req_misalign_o = 1'b0;
        case (req_size_i)
            MEM_SIZE_B: req_wmask_o = 8'h01 << req_off_i;
            MEM_SIZE_H: begin
                req_wmask_o    = 8'h03 << req_off_i;
                req_misalign_o = req_off_i[0];
            end
            MEM_SIZE_W: begin
                req_wmask_o    = 8'h0F << req_off_i;
                req_misalign_o = |req_off_i[1:0];
            end
            default: begin
                req_wmask_o    = 8'hFF;
                req_misalign_o = |req_off_i;
            end
        endcase
    end

    always_comb begin
        lane = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            MEM_SIZE_B: ld_data_o = {{(XLEN-8){~ld_unsigned_i & lane[7]}}, lane[7:0]};
            MEM_SIZE_H: ld_data_o = {{(XLEN-16){~ld_unsigned_i & lane[15]}}, lane[15:0]};
            MEM_SIZE_W: ld_data_o = {{(XLEN-32){~ld_unsigned_i & lane[31]}}, lane[31:0]};
            default:    ld_data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: bus request/response FSM and registered write-back packet
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.master  bus
);

    mem_state_e         state_q;
    logic               req_valid_q;
    logic [XLEN-1:0]    req_addr_q;
    logic               req_we_q;
    logic [XLEN-1:0]    req_wdata_q;
    logic [7:0]         req_wmask_q;
    logic [2:0]         ld_off_q;
    mem_size_e          ld_size_q;
    logic               ld_unsigned_q;
    logic               rd_wen_q;
    logic               wb_valid_q;
    logic [RADDR_W-1:0] wb_rd_addr_q;
    logic               wb_rd_wen_q;
    logic [XLEN-1:0]    wb_rd_data_q;
    logic               wb_misalign_q;

    logic [XLEN-1:0]    st_wdata;
    logic [7:0]         st_wmask;
    logic               misalign;
    logic [XLEN-1:0]    ld_data;
    logic               is_mem;
    logic               illegal;

    assign is_mem  = bus.ex_mem_rd ^ bus.ex_mem_wr;
    assign illegal = bus.ex_mem_rd & bus.ex_mem_wr;

    mem_stage_align u_align (
        .req_off_i        (bus.ex_rd_data[2:0]),
        .req_size_i       (mem_size_e'(bus.ex_mem_size)),
        .req_store_data_i (bus.ex_store_data),
        .req_wdata_o      (st_wdata),
        .req_wmask_o      (st_wmask),
        .req_misalign_o   (misalign),
        .ld_off_i         (ld_off_q),
        .ld_size_i        (ld_size_q),
        .ld_unsigned_i    (ld_unsigned_q),
        .ld_rdata_i       (bus.mem_rsp_rdata),
        .ld_data_o        (ld_data)
    );

    // wb_rd_addr/wb_rd_data are loaded at acceptance; only wb_valid qualifies them
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= MEM_IDLE;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_we_q      <= 1'b0;
            req_wdata_q   <= '0;
            req_wmask_q   <= 8'h00;
            ld_off_q      <= 3'd0;
            ld_size_q     <= MEM_SIZE_B;
            ld_unsigned_q <= 1'b0;
            rd_wen_q      <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_wen_q   <= 1'b0;
            wb_rd_data_q  <= '0;
            wb_misalign_q <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (bus.ex_valid) begin
                        wb_rd_addr_q  <= bus.ex_rd_addr;
                        wb_rd_data_q  <= bus.ex_rd_data;
                        wb_misalign_q <= 1'b0;
                        if (!is_mem) begin
                            wb_valid_q  <= 1'b1;
                            wb_rd_wen_q <= bus.ex_rd_wen & ~illegal;
                        end else if (misalign) begin
                            wb_valid_q    <= 1'b1;
                            wb_rd_wen_q   <= 1'b0;
                            wb_misalign_q <= 1'b1;
                        end else begin
                            req_valid_q   <= 1'b1;
                            req_addr_q    <= {bus.ex_rd_data[XLEN-1:3], 3'b000};
                            req_we_q      <= bus.ex_mem_wr;
                            req_wdata_q   <= st_wdata;
                            req_wmask_q   <= st_wmask;
                            ld_off_q      <= bus.ex_rd_data[2:0];
                            ld_size_q     <= mem_size_e'(bus.ex_mem_size);
                            ld_unsigned_q <= bus.ex_mem_unsigned;
                            rd_wen_q      <= bus.ex_rd_wen;
                            state_q       <= MEM_REQ;
                        end
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (req_we_q) begin
                            wb_valid_q  <= 1'b1;
                            wb_rd_wen_q <= 1'b0;
                            state_q     <= MEM_IDLE;
                        end else begin
                            state_q <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        wb_valid_q   <= 1'b1;
                        wb_rd_wen_q  <= rd_wen_q;
                        wb_rd_data_q <= ld_data;
                        state_q      <= MEM_IDLE;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    assign bus.ex_ready      = (state_q == MEM_IDLE);
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_we    = req_we_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wmask = req_wmask_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd_addr    = wb_rd_addr_q;
    assign bus.wb_rd_wen     = wb_rd_wen_q;
    assign bus.wb_rd_data    = wb_rd_data_q;
    assign bus.wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a bus slave model and write-back monitor
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          rdy_d;
        int          rsp_d;
        bit          aborted;
    } req_t;

    typedef struct {
        logic [4:0]  rd_addr;
        logic        rd_wen;
        logic [63:0] rd_data;
        logic        misalign;
        bit          chk_data;
        int          cyc;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] model_mask(input logic [63:0] addr, input int sz);
        int a = int'(addr % 8);
        int n = 1 << sz;
        logic [7:0] m = '0;
        for (int b = 0; b < 8; b++) m[b] = (b >= a) && (b < a + n);
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [63:0] data);
        int a = int'(addr % 8);
        logic [63:0] w = '0;
        for (int b = 0; b < 8; b++)
            if (b >= a) w[b*8 +: 8] = data[(b-a)*8 +: 8];
        return w;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input int sz,
                                               input bit uns, input logic [63:0] rdata);
        int a = int'(addr % 8);
        int n = 1 << sz;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = rdata[(a+i)*8 +: 8];
        if (!uns && v[8*n-1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    // op: 0 = ALU, 1 = load, 2 = store
    task automatic issue(input int op, input logic [63:0] addr, input logic [63:0] sdata,
                         input int sz, input bit uns, input logic [4:0] rd, input bit wen,
                         input logic [63:0] rdata, input int rdy_d, input int rsp_d, input bit abort);
        bit   ld  = (op == 1);
        bit   st  = (op == 2);
        bit   mis = (ld || st) && ((addr % (1 << sz)) != 0);
        int   t   = 0;
        int   n;
        req_t r;
        wb_t  w;
        bus.ex_valid        = 1'b1;
        bus.ex_rd_data      = addr;
        bus.ex_store_data   = sdata;
        bus.ex_mem_rd       = ld;
        bus.ex_mem_wr       = st;
        bus.ex_mem_size     = 2'(sz);
        bus.ex_mem_unsigned = uns;
        bus.ex_rd_addr      = rd;
        bus.ex_rd_wen       = wen;
        while (!bus.ex_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ex_ready_timeout", bus.ex_ready, 1);
        n = cyc;
        w.rd_addr  = rd;
        w.misalign = 1'b0;
        w.chk_data = 1'b0;
        w.rd_data  = '0;
        w.rd_wen   = 1'b0;
        if (!ld && !st) begin
            w.rd_wen   = wen;
            w.rd_data  = addr;
            w.chk_data = 1'b1;
            w.cyc      = n + 1;
        end else if (mis) begin
            w.misalign = 1'b1;
            w.cyc      = n + 1;
        end else begin
            r.addr    = addr & ~64'h7;
            r.we      = st;
            r.wdata   = model_wdata(addr, sdata);
            r.wmask   = model_mask(addr, sz);
            r.rdata   = rdata;
            r.rdy_d   = rdy_d;
            r.rsp_d   = rsp_d;
            r.aborted = abort;
            req_q.push_back(r);
            if (st) begin
                w.cyc = n + 2 + rdy_d;
            end else begin
                w.rd_wen   = wen;
                w.rd_data  = model_load(addr, sz, uns, rdata);
                w.chk_data = 1'b1;
                w.cyc      = n + 3 + rdy_d + rsp_d;
            end
        end
        if (!abort) wb_q.push_back(w);
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    task automatic check_req(input req_t e, input string name);
        chk({name, "_valid"}, bus.mem_req_valid, 1);
        chk({name, "_addr"}, bus.mem_req_addr, e.addr);
        chk({name, "_we"}, bus.mem_req_we, e.we);
        if (e.we) begin
            chk({name, "_wdata"}, bus.mem_req_wdata, e.wdata);
            chk({name, "_wmask"}, bus.mem_req_wmask, e.wmask);
        end
    endtask

    // Bus slave: checks each request against the expected queue and plays back its timing
    initial begin
        req_t e;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            if (rst && bus.mem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", bus.mem_req_valid, 0);
                    @(negedge clk);
                end else begin
                    e = req_q.pop_front();
                    for (int k = 0; k < e.rdy_d; k++) begin
                        check_req(e, "req_stall");
                        chk("ex_ready_stall", bus.ex_ready, 0);
                        bus.mem_rsp_valid = 1'($urandom % 2);
                        bus.mem_rsp_rdata = {$urandom, $urandom};
                        @(negedge clk);
                    end
                    check_req(e, "req");
                    bus.mem_req_ready = 1'b1;
                    bus.mem_rsp_valid = 1'b0;
                    @(negedge clk);
                    bus.mem_req_ready = 1'b0;
                    chk("req_drop", bus.mem_req_valid, 0);
                    if (!e.we) begin
                        for (int k = 0; k < e.rsp_d; k++) begin
                            if (!e.aborted) chk("ex_ready_wait", bus.ex_ready, 0);
                            @(negedge clk);
                        end
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rsp_rdata = e.rdata;
                        @(negedge clk);
                        bus.mem_rsp_valid = 1'b0;
                        bus.mem_rsp_rdata = {$urandom, $urandom};
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Write-back monitor
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (rst && bus.wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", bus.wb_valid, 0);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(w.cyc));
                    chk("wb_rd_wen", bus.wb_rd_wen, w.rd_wen);
                    chk("wb_misalign", bus.wb_misalign, w.misalign);
                    if (w.chk_data) begin
                        chk("wb_rd_addr", bus.wb_rd_addr, w.rd_addr);
                        chk("wb_rd_data", bus.wb_rd_data, w.rd_data);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        int op, sz;
        logic [63:0] a;
        bus.ex_valid        = 1'b0;
        bus.ex_rd_data      = '0;
        bus.ex_store_data   = '0;
        bus.ex_mem_rd       = 1'b0;
        bus.ex_mem_wr       = 1'b0;
        bus.ex_mem_size     = 2'd0;
        bus.ex_mem_unsigned = 1'b0;
        bus.ex_rd_addr      = '0;
        bus.ex_rd_wen       = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ex_ready", bus.ex_ready, 1);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_data", bus.wb_rd_data, 0);
        chk("rst_wb_misalign", bus.wb_misalign, 0);
        rst = 1'b1;
        @(negedge clk);

        issue(0, 64'h1234, 0, 3, 0, 5'd5, 1, 0, 0, 0, 0);
        issue(1, 64'h1003, 0, 0, 0, 5'd7, 1, 64'h0000_0000_8000_0000, 0, 0, 0);
        issue(1, 64'h1003, 0, 0, 1, 5'd8, 1, 64'h0000_0000_8000_0000, 0, 0, 0);
        issue(2, 64'h2006, 64'hBEEF, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        issue(1, 64'h3002, 0, 2, 0, 5'd9, 1, 0, 0, 0, 0);
        issue(1, 64'h4008, 0, 3, 0, 5'd10, 1, 64'h0123_4567_89AB_CDEF, 4, 2, 0);
        issue(2, 64'h5000, 64'h1122_3344_5566_7788, 3, 0, 5'd0, 0, 0, 4, 0, 0);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom % 3);
            sz = int'($urandom % 4);
            a  = {$urandom, $urandom};
            if (op != 0 && ($urandom % 4) != 0) a = a & ~((64'd1 << sz) - 1);
            issue(op, a, {$urandom, $urandom}, sz, 1'($urandom % 2), 5'($urandom),
                  1'($urandom % 2), {$urandom, $urandom}, int'($urandom % 4),
                  int'($urandom % 3), 0);
            if ($urandom % 4 == 0) repeat (1 + $urandom % 2) @(negedge clk);
        end

        t = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_wb", 64'(wb_q.size()), 0);
        chk("drain_req", 64'(req_q.size()), 0);
        repeat (2) @(negedge clk);

        // Reset while the load sits in WAIT; the slave's later response must be ignored
        issue(1, 64'h40, 0, 3, 0, 5'd3, 1, 64'hDEAD_BEEF_0000_0001, 0, 3, 1);
        @(negedge clk);
        chk("t6_wait_req_valid", bus.mem_req_valid, 0);
        chk("t6_wait_ex_ready", bus.ex_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_rst_ex_ready", bus.ex_ready, 1);
        chk("t6_rst_req_valid", bus.mem_req_valid, 0);
        chk("t6_rst_wb_valid", bus.wb_valid, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_late_wb_valid", bus.wb_valid, 0);
            chk("t6_late_ex_ready", bus.ex_ready, 1);
        end
        chk("t6_drain_req", 64'(req_q.size()), 0);
        issue(0, 64'hCAFE, 0, 3, 0, 5'd12, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("final_drain_wb", 64'(wb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
